// File: rtl/reorder_buffer_if.sv
// Issue, writeback, commit and status signals shared between the reorder buffer
// and its surroundings (issue stage, CDB, register file).
interface reorder_buffer_if #(
    parameter int ROB_WIDTH = 3
);
    logic                 rdy_in;
    logic                 flush_in;
    logic                 issue_valid;
    logic                 issue_has_rd;
    logic [4:0]           issue_rd;
    logic [ROB_WIDTH-1:0] issue_index;
    logic                 full;
    logic                 empty;
    logic                 wb_valid;
    logic [ROB_WIDTH-1:0] wb_index;
    logic [31:0]          wb_value;
    logic                 to_rf_valid;
    logic [4:0]           to_rf_rd;
    logic [31:0]          to_rf_wdata;
    logic [ROB_WIDTH-1:0] commit_index;

    modport master (
        output rdy_in, flush_in, issue_valid, issue_has_rd, issue_rd,
        output wb_valid, wb_index, wb_value,
        input  issue_index, full, empty,
        input  to_rf_valid, to_rf_rd, to_rf_wdata, commit_index
    );

    modport slave (
        input  rdy_in, flush_in, issue_valid, issue_has_rd, issue_rd,
        input  wb_valid, wb_index, wb_value,
        output issue_index, full, empty,
        output to_rf_valid, to_rf_rd, to_rf_wdata, commit_index
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: issue allocates at tail, the CDB marks
// entries ready, and the oldest ready entry retires into the register file.
module reorder_buffer #(
    parameter int ROB_WIDTH = 3
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    logic [DEPTH-1:0]     busy_r;
    logic [DEPTH-1:0]     ready_r;
    logic [DEPTH-1:0]     has_rd_r;
    logic [4:0]           rd_r    [DEPTH];
    logic [31:0]          value_r [DEPTH];
    logic [ROB_WIDTH-1:0] head_r;
    logic [ROB_WIDTH-1:0] tail_r;
    logic [ROB_WIDTH:0]   count_r;
    logic                 to_rf_valid_r;
    logic [4:0]           to_rf_rd_r;
    logic [31:0]          to_rf_wdata_r;
    logic [ROB_WIDTH-1:0] commit_index_r;

    logic                 full_s;
    logic                 empty_s;
    logic                 issue_ok_s;
    logic                 commit_s;

    // Status flags and the issue/commit decisions, all taken from pre-edge state
    always_comb begin
        full_s     = count_r[ROB_WIDTH];
        empty_s    = (count_r == '0);
        issue_ok_s = rob.issue_valid && !full_s;
        commit_s   = busy_r[head_r] && ready_r[head_r];
    end

    assign rob.issue_index  = tail_r;
    assign rob.full         = full_s;
    assign rob.empty        = empty_s;
    assign rob.to_rf_valid  = to_rf_valid_r;
    assign rob.to_rf_rd     = to_rf_rd_r;
    assign rob.to_rf_wdata  = to_rf_wdata_r;
    assign rob.commit_index = commit_index_r;

    // Queue state and commit port; rdy_in low freezes everything including the strobe
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy_r         <= '0;
            ready_r        <= '0;
            has_rd_r       <= '0;
            head_r         <= '0;
            tail_r         <= '0;
            count_r        <= '0;
            to_rf_valid_r  <= 1'b0;
            to_rf_rd_r     <= 5'd0;
            to_rf_wdata_r  <= 32'd0;
            commit_index_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]    <= 5'd0;
                value_r[i] <= 32'd0;
            end
        end else if (rob.rdy_in) begin
            if (rob.flush_in) begin
                busy_r        <= '0;
                ready_r       <= '0;
                head_r        <= '0;
                tail_r        <= '0;
                count_r       <= '0;
                to_rf_valid_r <= 1'b0;
            end else begin
                if (rob.wb_valid && busy_r[rob.wb_index]) begin
                    ready_r[rob.wb_index] <= 1'b1;
                    value_r[rob.wb_index] <= rob.wb_value;
                end
                // Commit clears after writeback so a late result to the retiring slot cannot revive it
                if (commit_s) begin
                    busy_r[head_r]  <= 1'b0;
                    ready_r[head_r] <= 1'b0;
                    head_r          <= head_r + ROB_WIDTH'(1);
                    commit_index_r  <= head_r;
                    to_rf_valid_r   <= has_rd_r[head_r] && (rd_r[head_r] != 5'd0);
                    to_rf_rd_r      <= rd_r[head_r];
                    to_rf_wdata_r   <= value_r[head_r];
                end else begin
                    to_rf_valid_r   <= 1'b0;
                end
                if (issue_ok_s) begin
                    busy_r[tail_r]   <= 1'b1;
                    ready_r[tail_r]  <= 1'b0;
                    has_rd_r[tail_r] <= rob.issue_has_rd;
                    rd_r[tail_r]     <= rob.issue_rd;
                    tail_r           <= tail_r + ROB_WIDTH'(1);
                end
                case ({issue_ok_s, commit_s})
                    2'b10:   count_r <= count_r + (ROB_WIDTH+1)'(1);
                    2'b01:   count_r <= count_r - (ROB_WIDTH+1)'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end
endmodule
